caravel_ascon_core: RTL and testbench

- ASCON-128 AEAD engine (k=128, r=64, a=12, b=6) with a bit-serial interface, sitting in the user-project area behind the caravel GPIO pads.
- Key, nonce, associated data and input data are shifted in serially, MSB first.
- On start, it encrypts or decrypts one message. It then asserts ready and shifts out the result data and the 128-bit tag serially, LSB first.

---
 rtl/ascon_pkg.sv | 26 ++
 rtl/ascon_round.sv | 33 +++
 rtl/caravel_ascon_core.sv | 127 ++++++++++++
 tb/tb_caravel_ascon_core.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared constants, FSM state type and permutation primitives for the ASCON-128 core.
package ascon_pkg;
   localparam int K        = 128;
   localparam int R        = 64;
   localparam int A_ROUNDS = 12;
   localparam int B_ROUNDS = 6;
   localparam int L        = 40;
   localparam int Y        = 104;

   localparam logic [63:0] IV = 64'h80400c0600000000;

   typedef enum logic [2:0] {IDLE, INIT, AD, PT, FINAL, DONE} state_t;

   // Column input is {x0,x1,x2,x3,x4}, x0 in the MSB.
   localparam logic [4:0] SBOX_LUT [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02, 5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18, 5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

   function automatic logic [4:0] sbox(input logic [4:0] col);
      return SBOX_LUT[col];
   endfunction

   function automatic logic [7:0] round_const(input logic [3:0] i);
      return {4'hF - i, i};
   endfunction
endpackage

// File: rtl/ascon_round.sv
// One ASCON permutation round: constant addition on x2, bit-sliced 5-bit S-box, linear diffusion.
module ascon_round
   import ascon_pkg::*;
(
   input  logic [319:0] s_in,
   input  logic [3:0]   rnd,
   output logic [319:0] s_out
);
   logic [63:0] a0, a1, a2, a3, a4;
   logic [63:0] z0, z1, z2, z3, z4;

   function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   assign {a0, a1, a2, a3, a4} = s_in ^ {184'b0, round_const(rnd), 128'b0};

   always_comb begin
      z0 = '0;
      z1 = '0;
      z2 = '0;
      z3 = '0;
      z4 = '0;
      for (int b = 0; b < 64; b++)
         {z0[b], z1[b], z2[b], z3[b], z4[b]} = sbox({a0[b], a1[b], a2[b], a3[b], a4[b]});
   end

   assign s_out = {z0 ^ rotr(z0, 19) ^ rotr(z0, 28),
                   z1 ^ rotr(z1, 61) ^ rotr(z1, 39),
                   z2 ^ rotr(z2, 1)  ^ rotr(z2, 6),
                   z3 ^ rotr(z3, 10) ^ rotr(z3, 17),
                   z4 ^ rotr(z4, 7)  ^ rotr(z4, 41)};
endmodule

// File: rtl/caravel_ascon_core.sv
// ASCON-128 AEAD core with MSB-first serial load and LSB-first serial result/tag readout.
// Define ASCON_UNROLL2_EN to apply two permutation rounds per clock (18 instead of 36 compute cycles).
module caravel_ascon_core
   import ascon_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic keyxSI,
   input  logic noncexSI,
   input  logic associated_dataxSI,
   input  logic input_dataxSI,
   input  logic ascon_startxSI,
   input  logic decrypt,
   output logic output_dataxSO,
   output logic tagxSO,
   output logic ascon_readyxSO,
   output logic flag_dec
);
`ifdef ASCON_UNROLL2_EN
   localparam logic [3:0] STEP = 4'd2;
`else
   localparam logic [3:0] STEP = 4'd1;
`endif
   localparam logic [3:0] LAST    = 4'd12 - STEP;
   localparam logic [3:0] B_START = 4'(A_ROUNDS - B_ROUNDS);

   state_t       state;
   logic [K-1:0] key, nonce, tag;
   logic [L-1:0] ad, blk1;
   logic [Y-1:0] data, result;
   logic [319:0] s, s_rnd, after_init, after_ad, after_pt;
   logic [R-1:0] x0, blk0, x0_last;
   logic [3:0]   cnt;
   logic [1:0]   hold;

`ifdef ASCON_UNROLL2_EN
   logic [319:0] s_mid;
   ascon_round u_round0 (.s_in(s),     .rnd(cnt),         .s_out(s_mid));
   ascon_round u_round1 (.s_in(s_mid), .rnd(cnt + 4'd1),  .s_out(s_rnd));
`else
   ascon_round u_round0 (.s_in(s),     .rnd(cnt),         .s_out(s_rnd));
`endif

   // Phase-exit transforms, taken on the clock that runs the phase's last round
   always_comb begin
      x0         = s_rnd[319:256];
      after_init = s_rnd ^ {{(320-K){1'b0}}, key};
      after_init[319:256] = after_init[319:256] ^ {ad, 1'b1, 23'b0};
      blk0       = x0 ^ data[Y-1:Y-R];
      after_ad   = {flag_dec ? data[Y-1:Y-R] : blk0, s_rnd[255:1], ~s_rnd[0]};
      blk1       = x0[R-1:R-L] ^ data[L-1:0];
      x0_last    = flag_dec ? {data[L-1:0], ~x0[23], x0[22:0]}
                            : x0 ^ {data[L-1:0], 1'b1, 23'b0};
      after_pt   = {x0_last, s_rnd[255:0]} ^ {{R{1'b0}}, key, 128'b0};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         key            <= '0;
         nonce          <= '0;
         ad             <= '0;
         data           <= '0;
         s              <= '0;
         cnt            <= '0;
         result         <= '0;
         tag            <= '0;
         hold           <= '0;
         ascon_readyxSO <= 1'b0;
         flag_dec       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // The start edge does not shift, so S and the later key xors see the same key
               if (ascon_startxSI) begin
                  flag_dec <= decrypt;
                  s        <= {IV, key, nonce};
                  cnt      <= '0;
                  state    <= INIT;
               end else begin
                  key   <= {key[K-2:0], keyxSI};
                  nonce <= {nonce[K-2:0], noncexSI};
                  ad    <= {ad[L-2:0], associated_dataxSI};
                  data  <= {data[Y-2:0], input_dataxSI};
               end
            end
            INIT, AD, PT, FINAL: begin
               if (cnt != LAST) begin
                  s   <= s_rnd;
                  cnt <= cnt + STEP;
               end else if (state == INIT) begin
                  s     <= after_init;
                  cnt   <= B_START;
                  state <= AD;
               end else if (state == AD) begin
                  s                <= after_ad;
                  result[Y-1:Y-R]  <= blk0;
                  cnt              <= B_START;
                  state            <= PT;
               end else if (state == PT) begin
                  s             <= after_pt;
                  result[L-1:0] <= blk1;
                  cnt           <= '0;
                  state         <= FINAL;
               end else begin
                  tag   <= s_rnd[127:0] ^ key;
                  state <= DONE;
               end
            end
            DONE: begin
               if (!ascon_readyxSO) begin
                  ascon_readyxSO <= 1'b1;
               end else if (hold != 2'd2) begin
                  hold <= hold + 2'd1;
               end else begin
                  result <= result >> 1;
                  tag    <= tag >> 1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign output_dataxSO = ascon_readyxSO & result[0];
   assign tagxSO         = ascon_readyxSO & tag[0];
endmodule

// File: tb/tb_caravel_ascon_core.sv
// Directed bench for caravel_ascon_core against a word-level ASCON-128 reference model.
module tb_caravel_ascon_core;
   import ascon_pkg::*;

   localparam logic [127:0] KEY   = 128'h6d4f8bbf60ec05a07b201d4e5b2119ac;
   localparam logic [127:0] NONCE = 128'h05885e606e1271b8d47a74c7b297a318;
   localparam logic [39:0]  ADV   = 40'h4153434f4e;
   localparam logic [103:0] PTV   = 104'h6173636f6e2d756e6963617373;
   localparam logic [103:0] CTV   = 104'h18490112f8d5867a830748390b;
`ifdef ASCON_UNROLL2_EN
   localparam int EXP_LAT  = 19;
   localparam int ABORT_AT = 10;
`else
   localparam int EXP_LAT  = 37;
   localparam int ABORT_AT = 20;
`endif

   typedef logic [0:4][63:0] st_t;

   logic clk = 1'b0, rst = 1'b1;
   logic keyxSI = 1'b0, noncexSI = 1'b0, associated_dataxSI = 1'b0, input_dataxSI = 1'b0;
   logic ascon_startxSI = 1'b0, decrypt = 1'b0;
   logic output_dataxSO, tagxSO, ascon_readyxSO, flag_dec;
   int   vectors = 0, miscompares = 0;

   always #5 clk = ~clk;

   caravel_ascon_core dut (
      .clk(clk), .rst(rst), .keyxSI(keyxSI), .noncexSI(noncexSI),
      .associated_dataxSI(associated_dataxSI), .input_dataxSI(input_dataxSI),
      .ascon_startxSI(ascon_startxSI), .decrypt(decrypt),
      .output_dataxSO(output_dataxSO), .tagxSO(tagxSO),
      .ascon_readyxSO(ascon_readyxSO), .flag_dec(flag_dec));

   function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   function automatic st_t permute(input st_t st, input int nr);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      {x0, x1, x2, x3, x4} = st;
      for (int r = 12 - nr; r < 12; r++) begin
         x2 = x2 ^ 64'((15 - r) * 16 + r);
         x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
         t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
         x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
         x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
         x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
         x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
         x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
         x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
         x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
      end
      return {x0, x1, x2, x3, x4};
   endfunction

   function automatic void model(input logic dec, input logic [127:0] k, input logic [127:0] n,
                                 input logic [39:0] a, input logic [103:0] din,
                                 output logic [103:0] res, output logic [127:0] tg);
      st_t         st;
      logic [63:0] o0;
      logic [39:0] o1;
      st = {64'h80400c0600000000, k, n};
      st = permute(st, 12);
      st[3] = st[3] ^ k[127:64];
      st[4] = st[4] ^ k[63:0];
      st[0] = st[0] ^ {a, 1'b1, 23'b0};
      st = permute(st, 6);
      st[4][0] = ~st[4][0];
      o0 = st[0] ^ din[103:40];
      st[0] = dec ? din[103:40] : o0;
      st = permute(st, 6);
      o1 = st[0][63:24] ^ din[39:0];
      st[0][63:24] = dec ? din[39:0] : o1;
      st[0][23] = ~st[0][23];
      st[1] = st[1] ^ k[127:64];
      st[2] = st[2] ^ k[63:0];
      st = permute(st, 12);
      tg  = {st[3], st[4]} ^ k;
      res = {o0, o1};
   endfunction

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("reset outputs", 128'({ascon_readyxSO, flag_dec, output_dataxSO, tagxSO}), 128'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Each register takes its value MSB first, zero-extended to the 128-cycle load window
   task automatic load(input logic [127:0] k, input logic [127:0] n,
                       input logic [39:0] a, input logic [103:0] d);
      logic [127:0] a_ext, d_ext;
      a_ext = {88'b0, a};
      d_ext = {24'b0, d};
      for (int i = 0; i < 128; i++) begin
         @(negedge clk);
         keyxSI             = k[127-i];
         noncexSI           = n[127-i];
         associated_dataxSI = a_ext[127-i];
         input_dataxSI      = d_ext[127-i];
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic dec, input int hs, input bit repulse,
                         input logic [103:0] exp_res, input logic [127:0] exp_tag,
                         output logic [103:0] got_res, output logic [127:0] got_tag);
      int           lat;
      logic [127:0] er;
      got_res = '0;
      got_tag = '0;
      er      = {24'b0, exp_res};
      @(negedge clk);
      decrypt        = dec;
      ascon_startxSI = 1'b1;
      @(posedge clk);
      #1;
      if (hs <= 1) ascon_startxSI = 1'b0;
      lat = 0;
      for (int n = 1; n <= 80 && lat == 0; n++) begin
         @(posedge clk);
         #1;
         if (n + 1 >= hs) ascon_startxSI = 1'b0;
         if (ascon_readyxSO) lat = n;
      end
      check("latency", 128'(lat), 128'(EXP_LAT));
      if (lat == 0) return;
      for (int h = 0; h < 2; h++) begin
         check($sformatf("hold%0d", h), 128'({ascon_readyxSO, flag_dec, output_dataxSO, tagxSO}),
               128'({1'b1, dec, er[0], exp_tag[0]}));
         @(posedge clk);
         #1;
      end
      for (int i = 0; i < 128; i++) begin
         if (repulse && i == 10) ascon_startxSI = 1'b1;
         if (repulse && i == 13) ascon_startxSI = 1'b0;
         check($sformatf("out bit %0d", i), 128'({ascon_readyxSO, flag_dec, output_dataxSO, tagxSO}),
               128'({1'b1, dec, er[i], exp_tag[i]}));
         if (i < 104) got_res[i] = output_dataxSO;
         got_tag[i] = tagxSO;
         @(posedge clk);
         #1;
      end
      check("drained", 128'({ascon_readyxSO, flag_dec, output_dataxSO, tagxSO}),
            128'({1'b1, dec, 2'b00}));
   endtask

   initial begin
      logic [103:0] m_ct, m_pt, g_res;
      logic [127:0] m_tag, m_tag_d, g_tag;

      repeat (3) @(posedge clk);
      #1;
      check("reset outputs", 128'({ascon_readyxSO, flag_dec, output_dataxSO, tagxSO}), 128'd0);
      check("reset state", 128'(dut.state), 128'(IDLE));
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("idle outputs", 128'({ascon_readyxSO, flag_dec, output_dataxSO, tagxSO}), 128'd0);

      model(1'b0, KEY, NONCE, ADV, PTV, m_ct, m_tag);
      model(1'b1, KEY, NONCE, ADV, CTV, m_pt, m_tag_d);
      check("model ct", 128'(m_ct), 128'(CTV));
      check("model pt", 128'(m_pt), 128'(PTV));
      check("model tag symmetry", m_tag_d, m_tag);

      // Encrypt with start held 5 cycles and re-pulsed while results stream out
      load(KEY, NONCE, ADV, PTV);
      check("load key", dut.key, KEY);
      check("load nonce", dut.nonce, NONCE);
      check("load ad", 128'(dut.ad), 128'(ADV));
      check("load data", 128'(dut.data), 128'(PTV));
      run_op(1'b0, 5, 1'b1, m_ct, m_tag, g_res, g_tag);
      check("enc ct", 128'(g_res), 128'(CTV));

      do_reset();
      load(KEY, NONCE, ADV, CTV);
      run_op(1'b1, 1, 1'b0, m_pt, m_tag, g_res, g_tag);
      check("dec pt", 128'(g_res), 128'(PTV));
      check("dec tag", g_tag, m_tag);

      // Abandon an encryption mid-permutation, then rerun from a fresh load
      do_reset();
      load(KEY, NONCE, ADV, PTV);
      @(negedge clk);
      decrypt        = 1'b0;
      ascon_startxSI = 1'b1;
      @(posedge clk);
      #1;
      ascon_startxSI = 1'b0;
      repeat (ABORT_AT) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort outputs", 128'({ascon_readyxSO, flag_dec, output_dataxSO, tagxSO}), 128'd0);
      check("abort state", 128'(dut.state), 128'(IDLE));
      check("abort cleared", 128'({dut.s == '0, dut.cnt == 4'd0, dut.key == '0}), 128'd7);
      @(negedge clk);
      rst = 1'b0;
      load(KEY, NONCE, ADV, PTV);
      run_op(1'b0, 1, 1'b0, m_ct, m_tag, g_res, g_tag);
      check("rerun ct", 128'(g_res), 128'(CTV));
      check("rerun tag", g_tag, m_tag);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
